// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache line writeback path.
//   DEF_LINE_W / DEF_BEAT_W / DEF_ADDR_W : default line, beat and address widths
//   BEATS / BEAT_IDX_W                   : beats per line and beat-index width
//   wb_state_e                           : writeback FSM states
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int DEF_LINE_W = 256;
    localparam int DEF_BEAT_W = 32;
    localparam int DEF_ADDR_W = 32;

    localparam int BEATS      = DEF_LINE_W / DEF_BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_line_buffer.sv
// -----------------------------------------------------------------------------
// wb_line_buffer
// Private copy of one cache line plus the beat-select mux feeding the memory
// write port. Holding the copy here lets the data array be refilled while the
// writeback is still draining.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   load           : capture line_in this cycle
//   line_in        : line contents from the data array
//   beat_sel       : beat index to present on beat_out
//   beat_out       : selected BEAT_W slice of the stored line
// -----------------------------------------------------------------------------
module wb_line_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LINE_W-1:0] line_in,
    input  logic [IDX_W-1:0]  beat_sel,
    output logic [BEAT_W-1:0] beat_out
);

    logic [LINE_W-1:0] line_r;

    // Line capture register; only reloaded when a new writeback is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_r <= {LINE_W{1'b0}};
        end else if (load) begin
            line_r <= line_in;
        end else begin
            line_r <= line_r;
        end
    end

    // Beat 0 is the least-significant slice of the line.
    always_comb begin
        beat_out = line_r[beat_sel*BEAT_W +: BEAT_W];
    end

endmodule

// File: rtl/cache_line_writeback.sv
// -----------------------------------------------------------------------------
// cache_line_writeback
// Captures a full cache line on wb_req and streams it to memory as BEAT_W
// beats over a valid/ready handshake, lowest beat first.
// Build option: define CACHE_WB_PARITY_EN to add mem_wpar (even parity per
// byte of mem_wdata, zero whenever mem_valid is low).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   wb_req              : start a writeback (only honoured while idle)
//   wb_addr             : line base byte address (line offset bits ignored)
//   line_data           : line contents from the data array
//   wb_busy             : writeback in progress (SEND or DONE)
//   wb_done             : one-cycle pulse after the final beat is accepted
//   mem_valid/mem_ready : beat handshake
//   mem_addr, mem_wdata : byte address and data of the current beat
//   mem_last            : current beat is the last of the line
//   mem_wpar            : per-byte even parity (CACHE_WB_PARITY_EN only)
// All outputs are registered; next-cycle values are computed from next state.
// -----------------------------------------------------------------------------
module cache_line_writeback
    import cache_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] line_data,
    output logic              wb_busy,
    output logic              wb_done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic              mem_last
`ifdef CACHE_WB_PARITY_EN
    ,
    output logic [BEAT_W/8-1:0] mem_wpar
`endif
);

    localparam int NUM_BEATS  = LINE_W / BEAT_W;
    localparam int IDX_W      = $clog2(NUM_BEATS);
    localparam int BEAT_SHIFT = $clog2(BEAT_W / 8);
    localparam logic [IDX_W-1:0]  LAST_BEAT  = IDX_W'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

    wb_state_e         state_r, state_nxt_s;
    logic [IDX_W-1:0]  beat_r, beat_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s;
    logic              load_s;
    logic              send_nxt_s;
    logic [BEAT_W-1:0] buf_beat_s;
    logic [BEAT_W-1:0] wdata_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;

    wb_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_line_buffer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .line_in  (line_data),
        .beat_sel (beat_nxt_s),
        .beat_out (buf_beat_s)
    );

    // Next-state, beat counter and base address logic.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        base_nxt_s  = base_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (wb_req) begin
                    state_nxt_s = SEND;
                    beat_nxt_s  = {IDX_W{1'b0}};
                    base_nxt_s  = wb_addr & ALIGN_MASK;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                // mem_valid is always high in SEND, so mem_ready alone means a transfer.
                if (mem_ready) begin
                    if (beat_r == LAST_BEAT) begin
                        state_nxt_s = DONE;
                    end else begin
                        beat_nxt_s = beat_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next-cycle beat data and address; the buffer is still loading on the
    // accept edge, so beat 0 is taken straight from line_data then.
    always_comb begin
        send_nxt_s = (state_nxt_s == SEND);
        if (load_s) begin
            wdata_nxt_s = line_data[BEAT_W-1:0];
        end else begin
            wdata_nxt_s = buf_beat_s;
        end
        addr_nxt_s = base_nxt_s + (ADDR_W'(beat_nxt_s) << BEAT_SHIFT);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            beat_r    <= {IDX_W{1'b0}};
            base_r    <= {ADDR_W{1'b0}};
            wb_busy   <= 1'b0;
            wb_done   <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {BEAT_W{1'b0}};
            mem_last  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            beat_r    <= beat_nxt_s;
            base_r    <= base_nxt_s;
            wb_busy   <= (state_nxt_s != IDLE);
            wb_done   <= (state_nxt_s == DONE);
            mem_valid <= send_nxt_s;
            mem_addr  <= send_nxt_s ? addr_nxt_s : {ADDR_W{1'b0}};
            mem_wdata <= send_nxt_s ? wdata_nxt_s : {BEAT_W{1'b0}};
            mem_last  <= send_nxt_s && (beat_nxt_s == LAST_BEAT);
        end
    end

`ifdef CACHE_WB_PARITY_EN
    // Even parity: each bit is the XOR of its byte.
    function automatic logic [BEAT_W/8-1:0] byte_parity(input logic [BEAT_W-1:0] d);
        logic [BEAT_W/8-1:0] p;
        p = {(BEAT_W/8){1'b0}};
        for (int i = 0; i < BEAT_W/8; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction

    // Parity register, aligned with mem_wdata and zero outside SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wpar <= {(BEAT_W/8){1'b0}};
        end else begin
            mem_wpar <= send_nxt_s ? byte_parity(wdata_nxt_s) : {(BEAT_W/8){1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_writeback.sv
// -----------------------------------------------------------------------------
// tb_cache_line_writeback
// Directed and randomized stimulus for cache_line_writeback. Expected beats
// are derived from the captured line and base address with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_cache_line_writeback;

    localparam int LW = 256;
    localparam int BW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] line_data;
    logic          wb_busy;
    logic          wb_done;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_last;
`ifdef CACHE_WB_PARITY_EN
    logic [BW/8-1:0] mem_wpar;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_line_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .wb_req    (wb_req),
        .wb_addr   (wb_addr),
        .line_data (line_data),
        .wb_busy   (wb_busy),
        .wb_done   (wb_done),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_last  (mem_last)
`ifdef CACHE_WB_PARITY_EN
        ,
        .mem_wpar  (mem_wpar)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: beat n is the n-th 32-bit word of the line, at the
    // line-aligned address plus 4*n.
    function automatic logic [31:0] model_beat(input logic [255:0] line, input int n);
        return line[n*32 +: 32];
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a, input int n);
        logic [31:0] base;
        base = (a / 32'd32) * 32'd32;
        return base + 32'(n * 4);
    endfunction

    function automatic logic [3:0] model_par(input logic [31:0] w);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
            p[k] = ($countones(w[k*8 +: 8]) % 2) == 1;
        end
        return p;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, mem_valid, 1'b0);
        check({tag, "_busy"},  wb_busy,   1'b0);
        check({tag, "_done"},  wb_done,   1'b0);
        check({tag, "_last"},  mem_last,  1'b0);
        check({tag, "_addr"},  mem_addr,  32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
`ifdef CACHE_WB_PARITY_EN
        check({tag, "_wpar"},  mem_wpar,  4'h0);
`endif
    endtask

    // One writeback. stall_beat/stall_len force a ready-low run at one beat,
    // poke_beat raises wb_req and scrambles inputs during that beat,
    // abort_beat pulses reset at that beat. Returns cycles spent streaming.
    task automatic do_wb(input logic [255:0] line, input logic [31:0] addr,
                         input int stall_pct, input int stall_beat, input int stall_len,
                         input int poke_beat, input int abort_beat, output int cycles);
        int   b;
        int   stalled;
        logic rdy;
        line_data = line;
        wb_addr   = addr;
        wb_req    = 1'b1;
        mem_ready = 1'b0;
        tick();
        wb_req  = 1'b0;
        b       = 0;
        cycles  = 0;
        stalled = 0;
        while (b < 8 && cycles < 300) begin
            if (b == abort_beat) begin
                reset = 1'b1;
                #1;
                check_idle("abort");
                #1;
                reset = 1'b0;
                return;
            end
            check("beat_valid", mem_valid, 1'b1);
            check("beat_busy",  wb_busy,   1'b1);
            check("beat_done",  wb_done,   1'b0);
            check("beat_addr",  mem_addr,  model_addr(addr, b));
            check("beat_data",  mem_wdata, model_beat(line, b));
            check("beat_last",  mem_last,  (b == 7) ? 1'b1 : 1'b0);
`ifdef CACHE_WB_PARITY_EN
            check("beat_wpar",  mem_wpar,  model_par(model_beat(line, b)));
`endif
            if (b == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            if (b == poke_beat) begin
                wb_req    = 1'b1;
                line_data = ~line ^ {8{$urandom}};
                wb_addr   = $urandom;
            end else begin
                wb_req = 1'b0;
            end
            mem_ready = rdy;
            tick();
            cycles++;
            if (rdy) begin
                b++;
            end
        end
        wb_req = 1'b0;
        check("beats_completed", b, 8);
        check("done_pulse", wb_done,   1'b1);
        check("done_valid", mem_valid, 1'b0);
        check("done_busy",  wb_busy,   1'b1);
        check("done_last",  mem_last,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] pat;
        logic [255:0] la;
        logic [31:0]  aa;
        int           cyc;

        reset     = 1'b1;
        wb_req    = 1'b0;
        mem_ready = 1'b0;
        wb_addr   = 32'h0;
        line_data = {LW{1'b0}};
        #12;
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Pattern line, no backpressure: 8 streaming cycles then done.
        for (int i = 0; i < 32; i++) begin
            pat[i*8 +: 8] = 8'(i);
        end
        do_wb(pat, 32'h0000_1234, 0, -1, 0, -1, -1, cyc);
        check("pattern_cycles", cyc, 8);
        tick();
        check_idle("pattern_after");

        // Three stalled cycles at beat 2.
        do_wb(pat, 32'h0000_1234, 0, 2, 3, -1, -1, cyc);
        check("stall_cycles", cyc, 11);
        tick();
        check_idle("stall_after");

        // Request and data change during beat 4 are ignored.
        la = rand_line();
        do_wb(la, 32'h8000_0040, 0, -1, 0, 4, -1, cyc);
        check("poke_cycles", cyc, 8);
        tick();
        check_idle("poke_after");
        tick();
        check_idle("poke_no_second");

        // Request in the DONE cycle is dropped; next-cycle request is taken.
        la = rand_line();
        do_wb(la, 32'h0000_2000, 0, -1, 0, -1, -1, cyc);
        wb_req    = 1'b1;
        line_data = rand_line();
        wb_addr   = 32'h0000_3000;
        tick();
        check("done_req_ignored_valid", mem_valid, 1'b0);
        check("done_req_ignored_busy",  wb_busy,   1'b0);
        la = rand_line();
        do_wb(la, 32'h0000_3004, 0, -1, 0, -1, -1, cyc);
        check("retry_cycles", cyc, 8);
        tick();
        check_idle("retry_after");

        // Reset at beat 5 abandons the line with no done pulse.
        la = rand_line();
        do_wb(la, 32'h0000_4000, 0, -1, 0, -1, 5, cyc);
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_done",  wb_done,   1'b0);
            check("abort_no_valid", mem_valid, 1'b0);
        end
        la = rand_line();
        do_wb(la, 32'h0000_4000, 0, -1, 0, -1, -1, cyc);
        check("abort_fresh_cycles", cyc, 8);
        tick();
        check_idle("abort_fresh_after");

`ifdef CACHE_WB_PARITY_EN
        // Known parity vector on beat 0.
        la = rand_line();
        la[31:0] = 32'h0103_0700;
        wb_req    = 1'b1;
        line_data = la;
        wb_addr   = 32'h0000_5000;
        tick();
        wb_req = 1'b0;
        check("parity_vector", mem_wpar, 4'b1010);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check("parity_done", wb_done, 1'b1);
        tick();
        check_idle("parity_after");
`endif

        // Randomized lines, addresses, backpressure and stray requests.
        for (int it = 0; it < 16; it++) begin
            la = rand_line();
            aa = (it % 4 == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            do_wb(la, aa, 30, -1, 0, (it % 3 == 0) ? int'($urandom_range(0, 7)) : -1, -1, cyc);
            tick();
            check_idle("rand_after");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_line_writeback.md
Name: cache_line_writeback

Overview:
- Read-side counterpart of the cache data array.
- Captures one full 256-bit line from the data array's output, then streams it to memory as 32-bit beats over a valid/ready handshake.
- Sits between the cache data array and the memory write port; it is driven by the cache controller on eviction of a dirty line.
- Holds its own copy of the line, so the data array may be refilled while the writeback is still in progress.

Parameters:
- LINE_W, 256, cache line width in bits; must be a multiple of BEAT_W.
- BEAT_W, 32, memory write beat width in bits.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_req  in  1  start writeback; sampled only in IDLE.
- wb_addr  in  ADDR_W  line base byte address; low log2(LINE_W/8) bits ignored and forced to 0.
- line_data  in  LINE_W  line contents from the cache data array output.
- wb_busy  out  1  high from the cycle after an accepted request through DONE.
- wb_done  out  1  one-cycle pulse after the last beat is accepted.
- mem_valid  out  1  beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  byte address of the current beat.
- mem_wdata  out  BEAT_W  current beat data.
- mem_last  out  1  high with the final beat.

Behaviour:
- Reset (async, active-high) values: all outputs 0, state IDLE, beat counter 0, buffer 0.
- BEATS = LINE_W/BEAT_W = 8. The beat counter is log2(BEATS) = 3 bits wide.
- States:
  - IDLE: on wb_req=1, capture line_data into the buffer and the aligned wb_addr into the base register, clear the beat counter, go to SEND. When wb_req=0, stay in IDLE.
  - SEND: mem_valid=1; mem_wdata = buffer[beat*BEAT_W +: BEAT_W]; mem_addr = base + beat*(BEAT_W/8); mem_last = (beat == BEATS-1).
    - A transfer occurs when mem_valid && mem_ready. On a transfer that is not the last beat, beat increments.
    - On a transfer of the last beat, go to DONE.
    - With mem_ready=0, hold all mem_* outputs stable. mem_valid is never withdrawn once asserted.
  - DONE: mem_valid=0, wb_done=1 for exactly this cycle, then go to IDLE.
- Beat order: beat 0 = line bits [31:0], ascending. Addresses are base, base+4, … base+28.
- wb_busy = (state != IDLE), registered.
- Latency with mem_ready held at 1: wb_req in cycle 0 → beats in cycles 1–8 → wb_done in cycle 9 → a new request is accepted in cycle 10 at the earliest.
- wb_req while busy, including the DONE cycle, is ignored and not queued.
- Changes on line_data or wb_addr after capture have no effect on the writeback in progress.
- Address arithmetic is modulo 2^ADDR_W. The aligned base cannot cross a line boundary.
- Reset mid-transfer abandons the line immediately: mem_valid drops asynchronously, and no wb_done is generated.

Optional Feature:
- Macro: CACHE_WB_PARITY_EN.
- When defined: an extra output port mem_wpar [BEAT_W/8-1:0] carries even parity per byte of mem_wdata. It is valid whenever mem_valid=1, is 0 otherwise, and is reset to 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - LINE_W, BEAT_W and ADDR_W defaults;
  - the derived constant BEATS and the beat-index width;
  - the writeback state typedef {IDLE, SEND, DONE}.
- One natural sub-module, wb_line_buffer: the LINE_W capture register with load enable, plus the BEAT_W beat-select mux indexed by the beat counter.
- The FSM, counter and address generation stay in the top module.

Test Plan:
- Pattern line (byte i = i) at wb_addr=0x0000_1234, mem_ready held 1 → beats at 0x1220..0x123C with data 0x03020100, 0x07060504, …, 0x1F1E1D1C; mem_last only on beat 7; wb_done in cycle 9.
- Backpressure: mem_ready low for 3 cycles during beat 2 → mem_addr 0x1228 and its data held stable with mem_valid=1; the sequence resumes with no lost or duplicated beat.
- Second wb_req and a changed line_data during beat 4 → output remains the original line; no second writeback starts after wb_done.
- wb_req asserted in the DONE cycle → ignored; wb_req in the following cycle → accepted, with mem_valid high the next cycle.
- reset pulsed during beat 5 → all outputs 0 immediately, state IDLE, no wb_done; a fresh request then completes normally.
- With CACHE_WB_PARITY_EN defined: beat data 0x01030700 → mem_wpar = 4'b1010.
